mux_2x1_stream_arb: RTL and testbench
=====================================

// Module: mux_2x1_stream_arb
// PURPOSE
// - Merging counterpart of the 1-to-2 demux: two valid/ready input streams combined onto one output stream.
// - Round-robin arbitration with packet lock: a granted input keeps the output until its beat with last=1 is accepted.
// - Registered output stage gives 1-cycle latency and cuts the combinational path from downstream.
// - Sits where two producers (e.g. demux branches after processing) share one consumer.
// PARAMETERS
// - DATA_W   8   payload width in bits
// PORTS
// - clk        in   1        single clock, all state updates on posedge
// - rst        in   1        synchronous, active-high reset
// - in0_valid  in   1        input 0 beat valid
// - in0_data   in   DATA_W   input 0 payload
// - in0_last   in   1        input 0 end-of-packet marker
// - in0_ready  out  1        input 0 beat accepted when in0_valid && in0_ready
// - in1_valid  in   1        input 1 beat valid
// - in1_data   in   DATA_W   input 1 payload
// - in1_last   in   1        input 1 end-of-packet marker
// - in1_ready  out  1        input 1 beat accepted when in1_valid && in1_ready
// - out_valid  out  1        output register holds a beat
// - out_data   out  DATA_W   registered payload
// - out_last   out  1        registered end-of-packet marker
// - out_sel    out  1        source of current output beat (0 = in0, 1 = in1)
// - out_ready  in   1        downstream accepts when out_valid && out_ready
// BEHAVIOUR
// - Reset (sync, high): out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE, last_grant=1 (in0 wins first).
// - load_en = !out_valid || out_ready; output register loads only when load_en and the granted input is valid.
// - States: IDLE, LOCK0, LOCK1.
// - IDLE: grant = in0 if only in0_valid; in1 if only in1_valid; if both, input != last_grant.
//   Granted beat accepted in this same cycle if load_en; last_grant <= grant.
//   Accepted beat with last=1 -> stay IDLE; last=0 -> LOCKgrant. Nothing accepted -> stay IDLE, last_grant unchanged.
// - LOCKx: only inx may transfer; other input's ready=0 regardless of its valid.
//   Accepted beat with last=1 -> IDLE; otherwise stay LOCKx. Bubbles (inx_valid=0) hold the lock.
// - inx_ready = load_en && (inx granted this cycle); never 1 for both inputs in the same cycle.
// - Latency: beat accepted at edge N appears on out_* after edge N; full throughput (1 beat/cycle) when out_ready=1.
// - Backpressure: out_valid && !out_ready -> out_* held stable, both in*_ready=0, state and last_grant frozen.
// - Simultaneous: out_ready=1 and new beat in same cycle -> old beat leaves, new beat loads (no bubble).
// - Reset mid-packet: in-flight beat and lock dropped, state IDLE, last_grant=1; upstream resets with same rst.
// - Payload passes unmodified; no width conversion, no data-dependent behaviour.
// STRUCTURE
// - Shared package: state encoding constants ST_IDLE=2'd0, ST_LOCK0=2'd1, ST_LOCK1=2'd2; SEL_IN0=1'b0, SEL_IN1=1'b1.
// - One natural sub-module: rr_arb_2 (2-requester round-robin arbiter, comb grant + last_grant register).
// - Top holds FSM, output register and ready generation.
// TESTING
// - Reset then in0 single beat 8'hA5 last=1, out_ready=1 -> out_valid=1 next cycle, out_data=8'hA5, out_sel=0, out_last=1.
// - Both valid every cycle, all beats last=1, out_ready=1 -> out_sel alternates 0,1,0,1 starting with 0 after reset.
// - in1 packet 8'h10,8'h11,8'h12 (last on 3rd) while in0 valid throughout -> three in1 beats contiguous on output, then in0 granted.
// - out_ready=0 for 4 cycles with out_valid=1, out_data=8'h3C -> out_data stays 8'h3C, in0_ready=in1_ready=0; releases on out_ready=1.
// - LOCK0 with in0_valid dropped 2 cycles mid-packet, in1_valid=1 -> in1_ready stays 0 until in0 beat with last=1 accepted.
// - rst asserted while in LOCK1 after 2 beats -> next cycle out_valid=0; both valid afterward -> first grant goes to in0.

Source files
------------

// File: rtl/mux_2x1_stream_arb_pkg.sv
// Shared constants and helpers for the 2-to-1 stream merger.
// State codes and source-select encodings.
package mux_2x1_stream_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOCK0 = 2'd1;
  localparam state_t ST_LOCK1 = 2'd2;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  function automatic logic lock_sel(
    input state_t st
  );
    return (st == ST_LOCK1) ? SEL_IN1 : SEL_IN0;
  endfunction

  function automatic state_t lock_state(
    input logic sel
  );
    return (sel == SEL_IN1) ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage

// File: rtl/mux_2x1_stream_arb_rr_arb_2.sv
// Two-requester round-robin arbiter.
// Combinational grant, registered last winner.
module rr_arb_2
  import mux_2x1_stream_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt_valid,
  output logic gnt_sel
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_valid = req0 || req1;
    gnt_sel   = SEL_IN0;
    if (req0 && req1) begin
      gnt_sel = ~last_grant_q;
    end else if (req1) begin
      gnt_sel = SEL_IN1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = gnt_sel;
    end
  end

  // Reset to in1 so in0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SEL_IN1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mux_2x1_stream_arb.sv
// Merges two valid/ready streams onto one registered output.
// Round-robin between packets, locked within a packet.
module mux_2x1_stream_arb
  import mux_2x1_stream_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel,
  input  logic              out_ready
);

  state_t            state_q;
  state_t            state_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic              out_last_q;
  logic              out_last_d;
  logic              out_sel_q;
  logic              out_sel_d;

  logic              load_en;
  logic              in_lock;
  logic              arb_valid;
  logic              arb_sel;
  logic              arb_update;
  logic              sel;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              granted;
  logic              accept;

  rr_arb_2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req0      (in0_valid),
    .req1      (in1_valid),
    .update    (arb_update),
    .gnt_valid (arb_valid),
    .gnt_sel   (arb_sel)
  );

  always_comb begin
    load_en = !out_valid_q || out_ready;
    in_lock = (state_q != ST_IDLE);
    sel     = in_lock ? lock_sel(state_q) : arb_sel;
    granted = in_lock || arb_valid;
  end

  always_comb begin
    sel_valid = in0_valid;
    sel_last  = in0_last;
    sel_data  = in0_data;
    if (sel == SEL_IN1) begin
      sel_valid = in1_valid;
      sel_last  = in1_last;
      sel_data  = in1_data;
    end
  end

  // A locked input keeps ready through its own bubbles.
  always_comb begin
    accept     = load_en && granted && sel_valid;
    arb_update = accept && !in_lock;
    in0_ready  = load_en && granted && (sel == SEL_IN0);
    in1_ready  = load_en && granted && (sel == SEL_IN1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !sel_last) begin
          state_d = lock_state(sel);
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (accept && sel_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_sel_d   = sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= SEL_IN0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_2x1_stream_arb.sv
// Bench for the 2-to-1 stream merger.
// Directed scenarios plus random traffic against a packet-level model.
module tb_mux_2x1_stream_arb;

  logic       clk;
  logic       rst;
  logic       in0_valid;
  logic [7:0] in0_data;
  logic       in0_last;
  logic       in0_ready;
  logic       in1_valid;
  logic [7:0] in1_data;
  logic       in1_last;
  logic       in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_sel;
  logic       out_ready;

  int total;
  int bad;

  logic       m_v;
  logic [7:0] m_d;
  logic       m_l;
  logic       m_s;
  int         owner;
  int         prio;

  mux_2x1_stream_arb #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(
    input logic       v0,
    input logic [7:0] d0,
    input logic       l0,
    input logic       v1,
    input logic [7:0] d1,
    input logic       l1,
    input logic       ordy,
    input logic       r
  );
    int   g;
    logic ld;
    logic gv;
    rst = r;
    in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    out_ready = ordy;
    #1;
    check("out_valid", out_valid, m_v);
    check("out_data", out_data, m_d);
    check("out_last", out_last, m_l);
    check("out_sel", out_sel, m_s);
    ld = !m_v || ordy;
    if (owner >= 0) g = owner;
    else if (v0 && v1) g = prio;
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    if (!r) begin
      check("in0_ready", in0_ready, ld && g == 0);
      check("in1_ready", in1_ready, ld && g == 1);
    end
    gv = (g == 0) ? v0 : (g == 1) ? v1 : 1'b0;
    if (r) begin
      m_v = 0; m_d = 0; m_l = 0; m_s = 0;
      owner = -1; prio = 0;
    end else if (ld && gv) begin
      m_v = 1;
      m_d = (g == 1) ? d1 : d0;
      m_l = (g == 1) ? l1 : l0;
      m_s = (g == 1);
      if (owner < 0) prio = 1 - g;
      owner = m_l ? -1 : g;
    end else if (ordy) begin
      m_v = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq[4];
    total = 0; bad = 0;
    m_v = 0; m_d = 0; m_l = 0; m_s = 0;
    owner = -1; prio = 0;
    exp_seq = '{0, 1, 0, 1};

    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);

    step(1, 8'hA5, 1, 0, 0, 0, 1, 0);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'hA5);
    check("t1_sel", out_sel, 0);
    check("t1_last", out_last, 1);

    step(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'(i), 1, 1, 8'(8'h80 + i), 1, 1, 0);
      check("alt_sel", out_sel, exp_seq[i]);
    end

    step(1, 8'h55, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h20, 1, 1, 8'(8'h10 + i), i == 2, 1, 0);
      check("pkt_sel", out_sel, 1);
      check("pkt_data", out_data, 8'h10 + i);
    end
    step(1, 8'h20, 1, 1, 8'h30, 1, 1, 0);
    check("pkt_after_sel", out_sel, 0);
    check("pkt_after_data", out_data, 8'h20);

    step(1, 8'h3C, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h77, 1, 1, 8'h78, 1, 0, 0);
      check("bp_data", out_data, 8'h3C);
      check("bp_r0", in0_ready, 0);
      check("bp_r1", in1_ready, 0);
    end
    step(1, 8'h77, 1, 1, 8'h78, 1, 1, 0);
    check("bp_release", out_valid, 1);

    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 8'h40, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1, 8'h90, 1, 1, 0);
      check("lock_r1", in1_ready, 0);
    end
    step(1, 8'h41, 1, 1, 8'h90, 1, 1, 0);
    check("lock_end", out_data, 8'h41);
    step(0, 0, 0, 1, 8'h90, 1, 1, 0);
    check("lock_next_sel", out_sel, 1);

    step(0, 0, 0, 1, 8'h60, 0, 1, 0);
    step(0, 0, 0, 1, 8'h61, 0, 1, 0);
    step(1, 8'h01, 1, 1, 8'h62, 1, 1, 1);
    check("rst_mid_valid", out_valid, 0);
    step(1, 8'h02, 1, 1, 8'h63, 1, 1, 0);
    check("rst_mid_sel", out_sel, 0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1), 8'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1), 8'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
